// File: rtl/bytewrite_ram_pipelined.sv
// -----------------------------------------------------------------------------
// bytewrite_ram_pipelined
//   Single-port byte-write block RAM with a valid/ready request port,
//   a selectable write mode (READ_FIRST / WRITE_FIRST / NO_CHANGE),
//   a configurable read pipeline (OUT_STAGES cycles) and an optional
//   hardware zero-sweep of the whole array after reset.
//
// Ports
//   clka       clock
//   rsta       asynchronous active-high reset
//   req_valid  request present
//   req_ready  block accepts a request this cycle (RUN state, not in reset)
//   addra      word address (AW bits)
//   dina       write data, NB_COL columns of COL_WIDTH bits
//   wea        per-column write enables; all zero is a read
//   douta      response data, held between responses
//   rd_valid   one-cycle strobe: douta carries a new response
//   busy       clear sweep in progress
//   oob_err    sticky: an out-of-range address was accepted
// -----------------------------------------------------------------------------

// Per-column response merge: new column where enabled, old column elsewhere.
module bytewrite_ram_pipelined_col #(
    parameter int W = 8
) (
    input  logic         sel_i,
    input  logic [W-1:0] new_i,
    input  logic [W-1:0] old_i,
    output logic [W-1:0] col_o
);
    assign col_o = sel_i ? new_i : old_i;
endmodule

module bytewrite_ram_pipelined #(
    parameter int    NB_COL         = 4,
    parameter int    COL_WIDTH      = 8,
    parameter int    RAM_DEPTH      = 1024,
    parameter string WRITE_MODE     = "READ_FIRST",
    parameter int    OUT_STAGES     = 2,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = "",
    localparam int   AW             = ($clog2(RAM_DEPTH) < 1) ? 1 : $clog2(RAM_DEPTH),
    localparam int   DW             = NB_COL * COL_WIDTH
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     addra,
    input  logic [DW-1:0]     dina,
    input  logic [NB_COL-1:0] wea,
    output logic [DW-1:0]     douta,
    output logic              rd_valid,
    output logic              busy,
    output logic              oob_err
);
    localparam logic [AW-1:0] LAST    = AW'(RAM_DEPTH - 1);
    localparam bit            WF_MODE = (WRITE_MODE == "WRITE_FIRST");
    localparam bit            NC_MODE = (WRITE_MODE == "NO_CHANGE");

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;

    logic [DW-1:0]   mem [RAM_DEPTH];

    logic            acc, in_rng, has_wr;
    logic [NB_COL-1:0] mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   rd_old, rd_mrg, rsp_word;
    logic            rsp_vld;

    logic [OUT_STAGES:1]         vld_pipe_q;
    logic [OUT_STAGES:1][DW-1:0] dat_pipe_q;
    logic                        oob_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            if (CLEAR_ON_RESET != 0) state_q <= ST_CLEAR;
            else                     state_q <= ST_RUN;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_CLEAR: begin
                // Terminal compare against the last real word: no wrap past depth.
                if (clr_addr_q == LAST) state_d = ST_RUN;
                else                    clr_addr_d = clr_addr_q + AW'(1);
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign busy      = (state_q == ST_CLEAR);
    assign req_ready = (state_q == ST_RUN) && !rsta;

    // ------------------------------------------------------- request decode
    assign acc    = req_valid && req_ready;
    assign in_rng = (addra <= LAST);
    assign has_wr = |wea;

    // Single write port shared by the sweep and accepted requests.
    // Nothing is written while rsta is high.
    always_comb begin
        mem_we   = '0;
        mem_addr = addra;
        mem_din  = dina;
        if (!rsta) begin
            if (state_q == ST_CLEAR) begin
                mem_we   = '1;
                mem_addr = clr_addr_q;
                mem_din  = '0;
            end else if (acc && in_rng) begin
                mem_we   = wea;
            end
        end
    end

    always_ff @(posedge clka) begin
        for (int c = 0; c < NB_COL; c++) begin
            if (mem_we[c]) mem[mem_addr][c*COL_WIDTH +: COL_WIDTH] <= mem_din[c*COL_WIDTH +: COL_WIDTH];
        end
    end

    // ------------------------------------------------------ response word
    assign rd_old = in_rng ? mem[addra] : '0;

    generate
        for (genvar c = 0; c < NB_COL; c++) begin : g_col
            bytewrite_ram_pipelined_col #(.W(COL_WIDTH)) u_col (
                .sel_i (wea[c]),
                .new_i (dina[c*COL_WIDTH +: COL_WIDTH]),
                .old_i (rd_old[c*COL_WIDTH +: COL_WIDTH]),
                .col_o (rd_mrg[c*COL_WIDTH +: COL_WIDTH])
            );
        end
    endgenerate

    // Out-of-range responses are forced to zero in every mode.
    assign rsp_word = !in_rng ? '0 : (WF_MODE ? rd_mrg : rd_old);
    // NO_CHANGE writes occupy a slot but never produce a response.
    assign rsp_vld  = acc && !(NC_MODE && has_wr);

    // ------------------------------------------------------ read pipeline
    // Each data stage only loads when a response enters it, so the last
    // stage (douta) holds the previous response between strobes.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
            oob_q      <= 1'b0;
        end else begin
            vld_pipe_q[1] <= rsp_vld;
            if (rsp_vld) dat_pipe_q[1] <= rsp_word;
            for (int s = 2; s <= OUT_STAGES; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                if (vld_pipe_q[s-1]) dat_pipe_q[s] <= dat_pipe_q[s-1];
            end
            if (acc && !in_rng) oob_q <= 1'b1;
        end
    end

    assign douta    = dat_pipe_q[OUT_STAGES];
    assign rd_valid = vld_pipe_q[OUT_STAGES];
    assign oob_err  = oob_q;

endmodule

// File: tb/tb_bytewrite_ram_pipelined.sv
// -----------------------------------------------------------------------------
// tb_bytewrite_ram_pipelined
//   Five instances share one stimulus stream: READ_FIRST/WRITE_FIRST/NO_CHANGE
//   at 2 stages, plus READ_FIRST at 1 and 4 stages. A word-level memory model
//   records every accepted request; each instance's expected output is looked
//   up from that history at its own latency.
// -----------------------------------------------------------------------------
module tb_bytewrite_ram_pipelined;
    localparam int N     = 5;
    localparam int DEPTH = 1000;
    localparam int HMAX  = 8192;
    localparam int OS_T[N] = '{2, 2, 2, 1, 4};
    localparam int MD_T[N] = '{0, 1, 2, 0, 0};   // 0 read-first, 1 write-first, 2 no-change

    logic        clka = 1'b0;
    logic        rsta;
    logic        req_valid = 1'b0;
    logic [9:0]  addra = '0;
    logic [31:0] dina = '0;
    logic [3:0]  wea = '0;
    logic [31:0] dout [N];
    logic        rv [N], rdy [N], bsy [N], oob [N];

    always #5 clka = ~clka;

    bytewrite_ram_pipelined #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .WRITE_MODE("READ_FIRST"),
        .OUT_STAGES(2), .CLEAR_ON_RESET(1), .INIT_FILE("")) u_rf2 (
        .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(rdy[0]), .addra(addra), .dina(dina),
        .wea(wea), .douta(dout[0]), .rd_valid(rv[0]), .busy(bsy[0]), .oob_err(oob[0]));
    bytewrite_ram_pipelined #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .WRITE_MODE("WRITE_FIRST"),
        .OUT_STAGES(2), .CLEAR_ON_RESET(1), .INIT_FILE("")) u_wf2 (
        .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(rdy[1]), .addra(addra), .dina(dina),
        .wea(wea), .douta(dout[1]), .rd_valid(rv[1]), .busy(bsy[1]), .oob_err(oob[1]));
    bytewrite_ram_pipelined #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .WRITE_MODE("NO_CHANGE"),
        .OUT_STAGES(2), .CLEAR_ON_RESET(1), .INIT_FILE("")) u_nc2 (
        .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(rdy[2]), .addra(addra), .dina(dina),
        .wea(wea), .douta(dout[2]), .rd_valid(rv[2]), .busy(bsy[2]), .oob_err(oob[2]));
    bytewrite_ram_pipelined #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .WRITE_MODE("READ_FIRST"),
        .OUT_STAGES(1), .CLEAR_ON_RESET(1), .INIT_FILE("")) u_rf1 (
        .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(rdy[3]), .addra(addra), .dina(dina),
        .wea(wea), .douta(dout[3]), .rd_valid(rv[3]), .busy(bsy[3]), .oob_err(oob[3]));
    bytewrite_ram_pipelined #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .WRITE_MODE("READ_FIRST"),
        .OUT_STAGES(4), .CLEAR_ON_RESET(1), .INIT_FILE("")) u_rf4 (
        .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(rdy[4]), .addra(addra), .dina(dina),
        .wea(wea), .douta(dout[4]), .rd_valid(rv[4]), .busy(bsy[4]), .oob_err(oob[4]));

    // ------------------------------------------------------------ model
    logic [31:0] rmem [DEPTH];
    int          clr_left, ecnt, rst_edge;
    bit          roob;
    bit          acc_h [HMAX];
    bit          wr_h  [HMAX];
    logic [31:0] old_h [HMAX];
    logic [31:0] mrg_h [HMAX];
    logic [31:0] exp_dout [N];
    int          n_tests, n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock: drive, advance model at the edge, check all instances after.
    task automatic cyc(input bit r, input bit v, input int a, input logic [31:0] d, input logic [3:0] w);
        bit          acc, ev;
        logic [31:0] o, m;
        int          n;
        rsta = r; req_valid = v; addra = a[9:0]; dina = d; wea = w;
        @(posedge clka);
        ecnt++;
        acc = v && !r && (clr_left == 0);
        o = (a < DEPTH) ? rmem[a] : 32'h0;
        m = o;
        for (int c = 0; c < 4; c++) if (w[c]) m[c*8 +: 8] = d[c*8 +: 8];
        if (a >= DEPTH) m = 32'h0;
        acc_h[ecnt] = acc; wr_h[ecnt] = (w != 0); old_h[ecnt] = o; mrg_h[ecnt] = m;
        if (r) begin
            clr_left = DEPTH; roob = 0; rst_edge = ecnt;
            for (int i = 0; i < N; i++) exp_dout[i] = 32'h0;
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0) for (int k = 0; k < DEPTH; k++) rmem[k] = 32'h0;
        end
        if (acc && a < DEPTH) rmem[a] = m;
        if (acc && a >= DEPTH) roob = 1;
        @(negedge clka);
        for (int i = 0; i < N; i++) begin
            n  = ecnt - OS_T[i] + 1;
            ev = 0;
            if (n > rst_edge && acc_h[n] && !(MD_T[i] == 2 && wr_h[n])) begin
                ev = 1;
                exp_dout[i] = (MD_T[i] == 1) ? mrg_h[n] : old_h[n];
            end
            chk($sformatf("u%0d rd_valid e%0d", i, ecnt), 32'(rv[i]), 32'(ev));
            chk($sformatf("u%0d douta e%0d", i, ecnt), dout[i], exp_dout[i]);
            chk($sformatf("u%0d req_ready e%0d", i, ecnt), 32'(rdy[i]), 32'(!r && clr_left == 0));
            chk($sformatf("u%0d busy e%0d", i, ecnt), 32'(bsy[i]), 32'(clr_left > 0));
            chk($sformatf("u%0d oob_err e%0d", i, ecnt), 32'(oob[i]), 32'(roob));
        end
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) cyc(0, 0, 0, 32'h0, 4'h0);
    endtask

    initial begin
        int cnt, a, sel;
        n_tests = 0; n_fail = 0; ecnt = 0; rst_edge = 0; clr_left = DEPTH; roob = 0;
        for (int i = 0; i < N; i++) exp_dout[i] = 32'h0;
        for (int k = 0; k < DEPTH; k++) rmem[k] = 32'h0;

        // reset, then time the clear sweep
        repeat (3) cyc(1, 0, 0, 32'h0, 4'h0);
        cnt = 0;
        for (int k = 0; k < 1500; k++) begin
            cyc(0, 0, 0, 32'h0, 4'h0);
            cnt++;
            if (rdy[0]) break;
        end
        chk("sweep_len", 32'(cnt), 32'd1000);

        // last word reads zero
        cyc(0, 1, 999, $urandom, 4'h0);
        idle(4);

        // byte enables across all modes
        cyc(0, 1, 7, 32'h11223344, 4'hf);
        cyc(0, 1, 7, 32'hAABBCCDD, 4'h5);
        cyc(0, 1, 7, $urandom, 4'h0);
        idle(1);
        chk("be_read_rf", dout[0], 32'h11BB33DD);
        chk("be_read_wf", dout[1], 32'h11BB33DD);
        chk("be_read_nc", dout[2], 32'h11BB33DD);
        idle(3);

        // streaming reads
        for (int k = 0; k < 8; k++) cyc(0, 1, k, $urandom, 4'hf);
        for (int k = 0; k < 8; k++) cyc(0, 1, k, $urandom, 4'h0);
        idle(4);

        // out of range
        cyc(0, 1, 1000, 32'hFFFFFFFF, 4'hf);
        cyc(0, 1, 1000, $urandom, 4'h0);
        cyc(0, 1, 0, $urandom, 4'h0);
        idle(4);
        chk("oob_sticky", 32'(oob[0]), 32'd1);

        // random traffic
        repeat (800) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = $urandom_range(0, 15);
            else if (sel < 8) a = $urandom_range(0, 999);
            else              a = $urandom_range(990, 1023);
            cyc(0, ($urandom_range(0, 3) != 0), a, $urandom,
                ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
        end
        idle(4);

        // reset restarts a sweep in progress
        cyc(0, 1, 5, 32'hDEADBEEF, 4'hf);
        idle(4);
        cyc(1, 0, 0, 32'h0, 4'h0);
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(0, 0, 0, 32'h0, 4'h0);
            if (bsy[0]) cnt++;
        end
        cyc(1, 0, 0, 32'h0, 4'h0);
        for (int k = 0; k < 1500; k++) begin
            cyc(0, 0, 0, 32'h0, 4'h0);
            cnt++;
            if (rdy[0]) break;
        end
        chk("midsweep_len", 32'(cnt), 32'd1300);
        chk("oob_cleared", 32'(oob[0]), 32'd0);
        cyc(0, 1, 5, $urandom, 4'h0);
        idle(1);
        chk("addr5_cleared", dout[0], 32'h0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
